// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and
// fills the IF/ID slot. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [15:0]         imem_rdata,
  input  logic                stall_i,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                if_valid,
  output logic [15:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         perf_fetch_cnt,
  output logic [15:0]         perf_bubble_cnt
`endif
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ALIGN_MASK = ~PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic [PC_WIDTH-1:0] target_al;
  logic                consumed;
  logic                slot_free;
  logic                handshake;
  logic                capture;

  // Handshake: a request transfers on a cycle with imem_req && imem_ready;
  // the address is held stable until then. Each transfer yields exactly one
  // imem_rvalid in a later cycle.
  assign consumed  = if_valid && !stall_i;
  assign slot_free = !if_valid || consumed;
  assign imem_req  = rst_n && (state == ST_REQ) && slot_free;
  assign imem_addr = pc;
  assign handshake = imem_req && imem_ready;
  assign target_al = redirect_target & PC_ALIGN_MASK;
  assign capture   = (state == ST_WAIT) && imem_rvalid && !redirect_valid;

  // Later assignments in this block take priority: capture over consume,
  // redirect over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc       <= RESET_PC_AL;
      req_pc   <= RESET_PC_AL;
      if_valid <= 1'b0;
      if_instr <= 16'h0000;
      if_pc    <= '0;
    end else begin
      if (consumed) if_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (handshake) begin
            req_pc <= pc;
            state  <= redirect_valid ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_REQ;
          end else if (redirect_valid) begin
            state <= ST_DRAIN;
          end
          if (capture) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= req_pc;
            pc       <= req_pc + PC_WIDTH'(2);
          end
        end
        ST_DRAIN: begin
          // The orphan response of a killed request is dropped here.
          if (imem_rvalid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
      if (redirect_valid) begin
        pc       <= target_al;
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 16'h0000;
      perf_bubble_cnt <= 16'h0000;
    end else begin
      if (capture && (perf_fetch_cnt != 16'hFFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (!if_valid && !stall_i && (perf_bubble_cnt != 16'hFFFF))
        perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// all checked against a transaction-level memory/slot model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_bubble_cnt;
  int          m_fetch;
  int          m_bubble;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] mem [256];

  // Model: expected IF/ID slot, next fetch address, and the one request the
  // memory currently owes a response for (live = not killed by a redirect).
  logic        m_valid;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_exp_addr;
  logic        m_out;
  logic        m_live;
  logic [7:0]  m_req_addr;
  int          m_resp_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_pc       = 8'h00;
    m_instr    = 16'h0000;
    m_exp_addr = 8'h00;
    m_out      = 1'b0;
    m_live     = 1'b0;
    m_req_addr = 8'h00;
    m_resp_cyc = 0;
`ifdef FETCH_PERF_CNT_EN
    m_fetch  = 0;
    m_bubble = 0;
`endif
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    rst_n          = 1'b0;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    model_reset();
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h00);
    chk("rst_if_instr", 32'(if_instr), 32'h0000);
    chk("rst_if_pc", 32'(if_pc), 32'h00);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
    chk("rst_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic step(input logic st, input logic rd, input logic [7:0] tgt,
                      input logic rdy, input int lat);
    logic rv, consumed, slot_free, e_req, hs, cap;
    rv = m_out && (cyc == m_resp_cyc);
    stall_i         = st;
    redirect_valid  = rd;
    redirect_target = tgt;
    imem_ready      = rdy;
    imem_rvalid     = rv;
    imem_rdata      = rv ? mem[m_req_addr] : 16'($urandom);
    #1;
    consumed  = m_valid && !st;
    slot_free = !m_valid || consumed;
    e_req     = !m_out && slot_free;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_exp_addr));
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    if (m_valid) begin
      chk("if_pc", 32'(if_pc), 32'(m_pc));
      chk("if_instr", 32'(if_instr), 32'(m_instr));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", 32'(perf_fetch_cnt), 32'(m_fetch));
    chk("perf_bubble", 32'(perf_bubble_cnt), 32'(m_bubble));
    if (!m_valid && !st && m_bubble < 65535) m_bubble++;
`endif
    hs  = e_req && rdy;
    cap = rv && m_live && !rd;
    if (rd) begin
      m_valid = 1'b0;
    end else if (cap) begin
      m_valid = 1'b1;
      m_pc    = m_req_addr;
      m_instr = mem[m_req_addr];
    end else if (consumed) begin
      m_valid = 1'b0;
    end
`ifdef FETCH_PERF_CNT_EN
    if (cap && m_fetch < 65535) m_fetch++;
`endif
    if (rv) m_out = 1'b0;
    if (hs) begin
      m_out      = 1'b1;
      m_live     = 1'b1;
      m_req_addr = m_exp_addr;
      m_resp_cyc = cyc + lat;
      m_exp_addr = m_exp_addr + 8'd2;
    end
    if (rd) begin
      m_live     = 1'b0;
      m_exp_addr = tgt & 8'hFE;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[6] = 16'hA5C3;
    model_reset();
    do_reset();

    // Sequential fetch, one instruction every two cycles.
    run(2);
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("seq_pc0", 32'(if_pc), 32'h00);
    chk("seq_instr0", 32'(if_instr), 32'(mem[0]));
    run(2);
    chk("seq_pc2", 32'(if_pc), 32'h02);
    run(2);
    chk("seq_pc4", 32'(if_pc), 32'h04);

    // Decode stall holds the slot and suppresses requests.
    run(2);
    chk("stall_instr_pre", 32'(if_instr), 32'hA5C3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1);
    chk("stall_hold_valid", 32'(if_valid), 32'd1);
    chk("stall_hold_instr", 32'(if_instr), 32'hA5C3);
    chk("stall_hold_pc", 32'(if_pc), 32'h06);
    step(1'b0, 1'b0, 8'h00, 1'b1, 3);

    // Redirect while waiting on a slow response.
    step(1'b0, 1'b1, 8'h41, 1'b0, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("redir_wait_valid", 32'(if_valid), 32'd0);
    chk("redir_wait_req", 32'(imem_req), 32'd1);
    chk("redir_wait_addr", 32'(imem_addr), 32'h40);
    run(2);
    chk("redir_wait_pc", 32'(if_pc), 32'h40);

    // Redirect in the same cycle as the response.
    step(1'b0, 1'b0, 8'h00, 1'b1, 2);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1);
    chk("redir_rv_valid", 32'(if_valid), 32'd0);
    chk("redir_rv_addr", 32'(imem_addr), 32'h80);
    run(2);
    chk("redir_rv_pc", 32'(if_pc), 32'h80);

    // PC wraps from 0xFE to 0x00.
    step(1'b0, 1'b1, 8'hFE, 1'b1, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("wrap_addr_fe", 32'(imem_addr), 32'hFE);
    run(2);
    chk("wrap_pc_fe", 32'(if_pc), 32'hFE);
    chk("wrap_next_addr", 32'(imem_addr), 32'h00);
    run(2);
    chk("wrap_pc_00", 32'(if_pc), 32'h00);

    // Reset while a request is outstanding.
    step(1'b0, 1'b0, 8'h00, 1'b1, 3);
    do_reset();
    run(2);
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    chk("post_rst_pc", 32'(if_pc), 32'h00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(99, 0) < 30),
           1'($urandom_range(99, 0) < 8),
           8'($urandom),
           1'($urandom_range(99, 0) < 65),
           $urandom_range(4, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit core. Owns the PC and issues single-outstanding requests to instruction memory.
- Holds the returned instruction in an output register (IF/ID slot) consumed by decode. Decode supplies the immediate generator with instruction[15:0].
- Supports decode back-pressure (stall) and branch/jump redirect with kill of any in-flight response.

Parameters:
- PC_WIDTH, 8, byte-address width of PC and memory address; bit 0 always 0 (halfword-aligned instructions).
- RESET_PC, 0, PC value loaded on reset; bit 0 ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  PC_WIDTH  fetch address; stable while imem_req=1 and not accepted.
- imem_ready  input  1  memory accepts request; handshake = imem_req && imem_ready.
- imem_rvalid  input  1  read data valid; earliest 1 cycle after acceptance; exactly one per accepted request.
- imem_rdata  input  16  instruction word.
- stall_i  input  1  decode cannot accept the IF/ID slot this cycle.
- redirect_valid  input  1  single-cycle PC redirect (taken branch/jump).
- redirect_target  input  PC_WIDTH  new PC; bit 0 forced to 0.
- if_valid  output  1  IF/ID slot holds a valid instruction.
- if_instr  output  16  instruction to decode / immediate generator.
- if_pc  output  PC_WIDTH  address of if_instr.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC with bit0=0; state=REQ.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=16'h0000, if_pc=0.
  - imem_req rises in the first cycle after rst_n deasserts.
- Slot consumed in a cycle when if_valid && !stall_i. slot_free = !if_valid || consumed.
- States:
  - REQ: imem_req = slot_free; imem_addr = pc. On handshake → WAIT, latch req_pc=pc. While !slot_free, imem_req=0.
  - WAIT: imem_req=0. On imem_rvalid:
    - if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, pc<=req_pc+2 (wraps modulo 2^PC_WIDTH) → REQ.
    - Capture is legal because a request is issued only when slot_free; the slot cannot be refilled before it is consumed.
  - DRAIN: imem_req=0; wait for the orphan imem_rvalid, discard its data → REQ.
- Consumption without a new capture clears if_valid next edge. Capture and consumption in the same cycle leave if_valid=1 with the new data.
- Stall: while stall_i=1 and if_valid=1, if_instr/if_pc/if_valid hold unchanged indefinitely.
- Latency: request accepted cycle N, rvalid cycle N+k (k≥1), if_valid visible cycle N+k+1. Peak throughput is one instruction per 2 cycles.
- Redirect (highest priority, overrides stall and capture in that cycle):
  - Next edge: if_valid<=0, pc<=redirect_target&~1.
  - In REQ with no handshake that cycle: request dropped, stay REQ. The address changes next cycle; this is legal because the request was never accepted.
  - In REQ with handshake the same cycle: → DRAIN.
  - In WAIT without rvalid: → DRAIN.
  - In WAIT with rvalid the same cycle: data discarded, → REQ.
  - In DRAIN: update pc, stay DRAIN.
- Redirect on consecutive cycles: the last target wins.
- Reset mid-transaction: everything returns to reset values. The memory is reset by the same rst_n, so no orphan rvalid is tracked across reset.
- imem_rvalid outside WAIT/DRAIN is a protocol error: ignored, no state change.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[15:0] and perf_bubble_cnt[15:0], both reset to 0.
  - perf_fetch_cnt increments on every capture into the slot (discarded responses excluded).
  - perf_bubble_cnt increments each cycle with !if_valid && !stall_i.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle after accept, data=PC-indexed → if_pc sequence 0x00,0x02,0x04 with if_valid every 2nd cycle; first if_valid 3 cycles after reset release.
- stall_i=1 for 5 cycles while if_valid=1, if_instr=16'hA5C3 → outputs held, imem_req=0 throughout; fetch of the next PC issued in the cycle stall_i drops.
- redirect_valid with target 0x41 while in WAIT (rvalid delayed 3 cycles) → orphan data discarded, if_valid=0, next imem_addr=0x40, next if_pc=0x40.
- redirect_valid coincident with imem_rvalid → data not captured, if_valid=0 next cycle, next request addr = target.
- PC_WIDTH=8, pc=0xFE sequential fetch → following if_pc=0x00 (wrap).
- rst_n pulsed low in WAIT → immediate async clear: if_valid=0, imem_req=0; restart fetch at RESET_PC. With FETCH_PERF_CNT_EN: counters read 0.
